bp_io_cmd_rr_arbiter: RTL

Two-requester arbiter sharing one BedRock IO command/response target (e.g. the nonsynth host MMIO) between the NBF loader (requester 0) and a core IO port (requester 1). It grants commands round-robin and records each grant's requester ID in an in-order tag FIFO. It routes each returning response to the requester that issued the matching command. It sits in the testbench/gateway IO path between the requesters and the single IO target.

---
 rtl/bp_io_cmd_rr_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bp_io_cmd_rr_arbiter.sv
// Two-requester BedRock IO command arbiter with an in-order tag FIFO for response routing.
// Define BP_IO_ARB_FIXED_PRIORITY_EN to make requester 0 always win ties (default: round-robin).
module bp_io_cmd_rr_arbiter #(
  parameter int unsigned cmd_width_p       = 128,
  parameter int unsigned resp_width_p      = 128,
  parameter int unsigned max_outstanding_p = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,

  input  logic [2*cmd_width_p-1:0]             req_cmd_i,
  input  logic [1:0]                           req_cmd_v_i,
  output logic [1:0]                           req_cmd_yumi_o,

  output logic [resp_width_p-1:0]              req_resp_o,
  output logic [1:0]                           req_resp_v_o,
  input  logic [1:0]                           req_resp_ready_i,

  output logic [cmd_width_p-1:0]               tgt_cmd_o,
  output logic                                 tgt_cmd_v_o,
  input  logic                                 tgt_cmd_ready_i,

  input  logic [resp_width_p-1:0]              tgt_resp_i,
  input  logic                                 tgt_resp_v_i,
  output logic                                 tgt_resp_yumi_o,

  output logic [$clog2(max_outstanding_p):0]   outstanding_o,
  output logic                                 err_o
);

  localparam int unsigned ptr_w_lp = $clog2(max_outstanding_p);
  localparam int unsigned cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(max_outstanding_p);

  logic                sel;
  logic                full, empty;
  logic                push, pop;
  logic                resp_v;
  logic                head;
  logic                spurious;
  logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                err_q;
  logic                tag_q [max_outstanding_p];

`ifdef BP_IO_ARB_FIXED_PRIORITY_EN
  always_comb begin
    sel = ~req_cmd_v_i[0] & req_cmd_v_i[1];
  end
`else
  logic last_q;

  always_comb begin
    sel = 1'b0;
    case (req_cmd_v_i)
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_q;
      default: sel = 1'b0;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q <= 1'b1;
    end else if (push) begin
      last_q <= sel;
    end
  end
`endif

  assign full  = (count_q == full_cnt_lp);
  assign empty = (count_q == '0);

  assign tgt_cmd_v_o = (|req_cmd_v_i) & ~full;
  assign tgt_cmd_o   = sel ? req_cmd_i[cmd_width_p +: cmd_width_p] : req_cmd_i[0 +: cmd_width_p];

  // Gated by reset so no command is acknowledged while the FIFO is held empty.
  assign push           = tgt_cmd_v_o & tgt_cmd_ready_i & reset_n_i;
  assign req_cmd_yumi_o = push ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign head            = tag_q[rd_ptr_q];
  assign resp_v          = tgt_resp_v_i & ~empty;
  assign req_resp_o      = tgt_resp_i;
  assign req_resp_v_o    = resp_v ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign pop             = resp_v & req_resp_ready_i[head];
  assign tgt_resp_yumi_o = pop;
  assign spurious        = tgt_resp_v_i & empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      err_q   <= err_q | spurious;
    end
  end

  // Tag payload needs no reset; occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (push) tag_q[wr_ptr_q] <= sel;
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule
